// File: rtl/result_sram_pipe_if.sv
// Request/response bundle for result_sram_pipe: access strobes and address/data
// on the requester side, read data plus Valid/Busy/Err status from the memory side.
interface result_sram_pipe_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 17
);
   logic                    En;
   logic                    RW;
   logic                    Acc;
   logic [ADDR_WIDTH-1:0]   Addr;
   logic [DATA_WIDTH-1:0]   Data_In;
   logic [DATA_WIDTH/8-1:0] Byte_En;
   logic                    Clr;
   logic [DATA_WIDTH-1:0]   Data_Out;
   logic                    Valid;
   logic                    Busy;
   logic                    Err;

   modport master (
      output En, RW, Acc, Addr, Data_In, Byte_En, Clr,
      input  Data_Out, Valid, Busy, Err
   );

   modport slave (
      input  En, RW, Acc, Addr, Data_In, Byte_En, Clr,
      output Data_Out, Valid, Busy, Err
   );
endinterface

// File: rtl/result_sram_pipe.sv
// Single-port result SRAM with byte-masked writes, read-modify-write accumulate
// and a sequential full-memory clear (also used to initialise after reset).
module result_sram_pipe #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 17
) (
   input logic                Clk,
   input logic                Rst,
   result_sram_pipe_if.slave  bus
);

   localparam int unsigned NB = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, ACC_WR, CLEAR} state_t;

   state_t                  state;
   state_t                  state_n;
   logic [ADDR_WIDTH-1:0]   clr_cnt;
   logic [DATA_WIDTH-1:0]   mem [0:(2**ADDR_WIDTH)-1];

   logic [ADDR_WIDTH-1:0]   acc_addr;
   logic [DATA_WIDTH-1:0]   acc_data;
   logic [DATA_WIDTH-1:0]   acc_old;
   logic [DATA_WIDTH-1:0]   acc_sum;

   logic                    we;
   logic [ADDR_WIDTH-1:0]   waddr;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [NB-1:0]           wbe;
   logic                    rd_req;
   logic                    acc_req;
   logic                    err_n;

   logic [DATA_WIDTH-1:0]   dout_q;
   logic                    valid_q;
   logic                    err_q;

   assign acc_sum = acc_old + acc_data;

   // Every memory update funnels through this one write port, so reads never race a write.
   always_comb begin
      state_n = state;
      we      = 1'b0;
      waddr   = bus.Addr;
      wdata   = bus.Data_In;
      wbe     = bus.Byte_En;
      rd_req  = 1'b0;
      acc_req = 1'b0;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.Clr) begin
               state_n = CLEAR;
               err_n   = bus.En;
            end else if (bus.En) begin
               if (!bus.RW) begin
                  rd_req = 1'b1;
               end else if (bus.Acc) begin
                  acc_req = 1'b1;
                  state_n = ACC_WR;
               end else begin
                  we = 1'b1;
               end
            end
         end
         ACC_WR: begin
            we      = 1'b1;
            waddr   = acc_addr;
            wdata   = acc_sum;
            wbe     = '1;
            err_n   = bus.En;
            state_n = IDLE;
         end
         CLEAR: begin
            we    = 1'b1;
            waddr = clr_cnt;
            wdata = '0;
            wbe   = '1;
            err_n = bus.En;
            if (clr_cnt == '1) begin
               state_n = IDLE;
            end
         end
         default: state_n = CLEAR;
      endcase
      if (Rst) begin
         state_n = CLEAR;
         we      = 1'b0;
         rd_req  = 1'b0;
         acc_req = 1'b0;
         err_n   = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      for (int unsigned i = 0; i < NB; i++) begin
         if (we && wbe[i]) begin
            mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (acc_req) begin
         acc_addr <= bus.Addr;
         acc_data <= bus.Data_In;
         acc_old  <= mem[bus.Addr];
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_n;
         // Natural wrap of the counter lands back on zero exactly as CLEAR exits.
         clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
         valid_q <= rd_req || (state == ACC_WR);
         err_q   <= err_n;
         if (rd_req) begin
            dout_q <= mem[bus.Addr];
         end else if (state == ACC_WR) begin
            dout_q <= acc_sum;
         end
      end
   end

   assign bus.Data_Out = dout_q;
   assign bus.Valid    = valid_q;
   assign bus.Err      = err_q;
   assign bus.Busy     = (state != IDLE);

endmodule

// File: tb/tb_result_sram_pipe.sv
// Scoreboard bench for result_sram_pipe at ADDR_WIDTH=4, DATA_WIDTH=16.
module tb_result_sram_pipe;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 4;

   logic Clk = 1'b0;
   logic Rst = 1'b1;

   result_sram_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   result_sram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [DW-1:0] data;
      int unsigned   due;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] model [16];
   int unsigned   cyc = 0;
   int            n_checks = 0;
   int            n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Response monitor: one cycle counter tick per rising edge, outputs sampled 1ns later.
   always @(posedge Clk) begin
      cyc++;
      #1;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         check_eq("valid_pulse", {31'd0, bus.Valid}, 32'd1);
         check_eq("data_out", {16'd0, bus.Data_Out}, {16'd0, exp_q[0].data});
         void'(exp_q.pop_front());
      end else if (bus.Valid === 1'b1) begin
         check_eq("valid_unexpected", 32'd1, 32'd0);
      end
   end

   task automatic idle_in();
      bus.En = 1'b0; bus.RW = 1'b0; bus.Acc = 1'b0; bus.Clr = 1'b0;
      bus.Addr = '0; bus.Data_In = '0; bus.Byte_En = '0;
   endtask

   task automatic issue_read(input logic [AW-1:0] a);
      exp_t e;
      idle_in();
      bus.En = 1'b1; bus.Addr = a;
      e.data = model[a]; e.due = cyc + 1;
      exp_q.push_back(e);
      @(negedge Clk);
   endtask

   task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
      idle_in();
      bus.En = 1'b1; bus.RW = 1'b1; bus.Addr = a; bus.Data_In = d; bus.Byte_En = be;
      for (int i = 0; i < 2; i++) if (be[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
      @(negedge Clk);
   endtask

   task automatic issue_acc(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_out);
      exp_t e;
      idle_in();
      bus.En = 1'b1; bus.RW = 1'b1; bus.Acc = 1'b1; bus.Addr = a; bus.Data_In = d;
      bus.Byte_En = 2'b00;
      if (expect_out) begin
         model[a] = model[a] + d;
         e.data = model[a]; e.due = cyc + 2;
         exp_q.push_back(e);
      end
      @(negedge Clk);
   endtask

   task automatic busy_len(output int n);
      n = 0;
      while (bus.Busy === 1'b1 && n < 100) begin
         n++;
         @(negedge Clk);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 16; i++) model[i] = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      idle_in();
      clear_model();
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      check_eq("rst_busy", {31'd0, bus.Busy}, 32'd1);
      check_eq("rst_valid", {31'd0, bus.Valid}, 32'd0);
      check_eq("rst_err", {31'd0, bus.Err}, 32'd0);
      check_eq("rst_dout", {16'd0, bus.Data_Out}, 32'd0);
      busy_len(n);
      check_eq("rst_clear_len", n, 32'd16);

      for (int a = 0; a < 16; a++) issue_read(4'(a));
      idle_in();
      @(negedge Clk);
      check_eq("hold_valid_low", {31'd0, bus.Valid}, 32'd0);
      check_eq("hold_dout_zero", {16'd0, bus.Data_Out}, 32'd0);

      issue_write(4'd3, 16'hABCD, 2'b11);
      issue_write(4'd3, 16'h1200, 2'b10);
      issue_read(4'd3);
      idle_in();
      @(negedge Clk);
      check_eq("hold_dout_12cd", {16'd0, bus.Data_Out}, 32'h12CD);

      issue_write(4'd5, 16'hFFF0, 2'b11);
      issue_acc(4'd5, 16'h0020, 1'b1);
      check_eq("acc_busy", {31'd0, bus.Busy}, 32'd1);
      idle_in();
      @(negedge Clk);
      check_eq("acc_busy_done", {31'd0, bus.Busy}, 32'd0);
      issue_read(4'd5);

      issue_acc(4'd5, 16'h0001, 1'b1);
      check_eq("acc2_busy", {31'd0, bus.Busy}, 32'd1);
      idle_in();
      bus.En = 1'b1; bus.RW = 1'b1; bus.Addr = 4'd5; bus.Data_In = 16'hDEAD; bus.Byte_En = 2'b11;
      @(negedge Clk);
      idle_in();
      check_eq("drop_err", {31'd0, bus.Err}, 32'd1);
      @(negedge Clk);
      check_eq("drop_err_once", {31'd0, bus.Err}, 32'd0);
      issue_read(4'd5);

      idle_in();
      bus.Clr = 1'b1; bus.En = 1'b1; bus.Addr = 4'd3;
      @(negedge Clk);
      idle_in();
      clear_model();
      check_eq("clr_en_err", {31'd0, bus.Err}, 32'd1);
      busy_len(n);
      check_eq("clr_len", n, 32'd16);
      for (int a = 0; a < 16; a++) issue_read(4'(a));

      issue_write(4'd9, 16'h7777, 2'b11);
      idle_in();
      bus.Clr = 1'b1;
      @(negedge Clk);
      bus.Clr = 1'b1;
      @(negedge Clk);
      bus.Clr = 1'b0;
      check_eq("clr_in_clear_no_err", {31'd0, bus.Err}, 32'd0);
      repeat (5) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      clear_model();
      busy_len(n);
      check_eq("rst_mid_clear_len", n, 32'd16);
      issue_read(4'd9);
      issue_read(4'd0);

      issue_write(4'd7, 16'h0005, 2'b11);
      issue_acc(4'd7, 16'h0001, 1'b0);
      idle_in();
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      clear_model();
      check_eq("rst_acc_valid", {31'd0, bus.Valid}, 32'd0);
      busy_len(n);
      check_eq("rst_acc_clear_len", n, 32'd16);
      issue_read(4'd7);
      idle_in();

      n = 0;
      while (exp_q.size() > 0 && n < 10) begin
         n++;
         @(negedge Clk);
      end
      check_eq("queue_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
